e_mdu: RTL

Execute-stage multiply/divide unit for the 5-stage MIPS pipeline. Holds the architectural HI/LO registers and runs MULT/MULTU/DIV/DIVU as a fixed-latency multi-cycle operation. Raises `busy` so the hazard unit can stall dependent MDU instructions. Drives the value the execute→memory pipeline register latches as its `mdu` field (MFHI/MFLO result).

---
 rtl/e_mdu_if.sv | 23 ++
 rtl/e_mdu.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/e_mdu_if.sv
// e_mdu_if: execute-stage MDU request/result bundle.
// master drives the E-stage operands and op; slave is the multiply/divide unit.
interface e_mdu_if;
    logic        start;
    logic [3:0]  op;
    logic        req;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] out;

    modport master (
        output start, op, req, a, b,
        input  busy, hi, lo, out
    );

    modport slave (
        input  start, op, req, a, b,
        output busy, hi, lo, out
    );
endinterface

// File: rtl/e_mdu.sv
// e_mdu: MIPS execute-stage multiply/divide unit with architectural HI/LO.
// Results are computed at accept time and parked in t_hi/t_lo; they are
// committed to HI/LO after a fixed busy window (MULT_CYCLES / DIV_CYCLES).
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (ops 9-12);
// when undefined those ops behave as NONE.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic   clk,
    input logic   reset,
    e_mdu_if.slave mdu
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

    typedef enum logic {IDLE, BUSY} state_e;

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic               busy_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;
    logic [31:0]        t_hi;
    logic [31:0]        t_lo;

    logic               acc;
    logic               launch;
    logic [CNT_W-1:0]   launch_cyc;
    logic [63:0]        res;

    logic signed [63:0] sa_ext;
    logic signed [63:0] sb_ext;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;

    // Signed divide: quotient truncates toward zero, remainder takes the
    // dividend's sign. Divide by zero yields {HI,LO} = {n, all-ones}.
    // 0x8000_0000 / -1 falls out naturally as quotient 0x8000_0000, rem 0.
    function automatic logic [63:0] div_signed(input logic [31:0] n, input logic [31:0] d);
        logic [31:0] mn;
        logic [31:0] md;
        logic [31:0] q;
        logic [31:0] r;
        if (d == 32'd0) begin
            return {n, 32'hFFFF_FFFF};
        end
        mn = n[31] ? (32'd0 - n) : n;
        md = d[31] ? (32'd0 - d) : d;
        q  = mn / md;
        r  = mn % md;
        if (n[31] ^ d[31]) q = 32'd0 - q;
        if (n[31])         r = 32'd0 - r;
        return {r, q};
    endfunction

    // Unsigned divide with the same divide-by-zero convention.
    function automatic logic [63:0] div_unsigned(input logic [31:0] n, input logic [31:0] d);
        if (d == 32'd0) begin
            return {n, 32'hFFFF_FFFF};
        end
        return {n % d, n / d};
    endfunction

    assign sa_ext = {{32{mdu.a[31]}}, mdu.a};
    assign sb_ext = {{32{mdu.b[31]}}, mdu.b};
    assign prod_s = sa_ext * sb_ext;
    assign prod_u = {32'd0, mdu.a} * {32'd0, mdu.b};

    assign acc = mdu.start & ~mdu.req & (state == IDLE);

    // Decode the op into the 64-bit result to park and the busy window length.
    always_comb begin
        res        = 64'd0;
        launch     = 1'b0;
        launch_cyc = '0;
        case (mdu.op)
            OP_MULT:  begin res = prod_s;                          launch = 1'b1; launch_cyc = CNT_W'(MULT_CYCLES); end
            OP_MULTU: begin res = prod_u;                          launch = 1'b1; launch_cyc = CNT_W'(MULT_CYCLES); end
            OP_DIV:   begin res = div_signed(mdu.a, mdu.b);        launch = 1'b1; launch_cyc = CNT_W'(DIV_CYCLES);  end
            OP_DIVU:  begin res = div_unsigned(mdu.a, mdu.b);      launch = 1'b1; launch_cyc = CNT_W'(DIV_CYCLES);  end
`ifdef MDU_MADD_EN
            OP_MADD:  begin res = {hi_q, lo_q} + prod_s;           launch = 1'b1; launch_cyc = CNT_W'(MULT_CYCLES); end
            OP_MADDU: begin res = {hi_q, lo_q} + prod_u;           launch = 1'b1; launch_cyc = CNT_W'(MULT_CYCLES); end
            OP_MSUB:  begin res = {hi_q, lo_q} - prod_s;           launch = 1'b1; launch_cyc = CNT_W'(MULT_CYCLES); end
            OP_MSUBU: begin res = {hi_q, lo_q} - prod_u;           launch = 1'b1; launch_cyc = CNT_W'(MULT_CYCLES); end
`endif
            default:  begin res = 64'd0;                           launch = 1'b0; launch_cyc = '0;                  end
        endcase
    end

    // Park the computed result at accept; data path, no reset needed.
    always_ff @(posedge clk) begin
        if (acc && launch) begin
            t_hi <= res[63:32];
            t_lo <= res[31:0];
        end
    end

    // Control FSM: accept/MTHI/MTLO in IDLE, count down and commit in BUSY.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc) begin
                        if (launch) begin
                            cnt    <= launch_cyc;
                            busy_q <= 1'b1;
                            state  <= BUSY;
                        end else if (mdu.op == OP_MTHI) begin
                            hi_q <= mdu.a;
                        end else if (mdu.op == OP_MTLO) begin
                            lo_q <= mdu.a;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        hi_q   <= t_hi;
                        lo_q   <= t_lo;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign mdu.busy = busy_q;
    assign mdu.hi   = hi_q;
    assign mdu.lo   = lo_q;
    assign mdu.out  = (mdu.op == OP_MFHI) ? hi_q :
                      (mdu.op == OP_MFLO) ? lo_q : 32'd0;

endmodule
